// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: buffers two lines of a raster pixel stream and
// emits one column-major 72-bit window per interior pixel through a single output register.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] window,
    output logic        window_valid,
    input  logic        window_ready,
    output logic [11:0] win_x,
    output logic [11:0] win_y,
    output logic        frame_done
);

    localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [11:0] col_r;
    logic [11:0] row_r;
    logic [AW-1:0] addr_s;
    logic [7:0]  line_a_mem [IMG_WIDTH];
    logic [7:0]  line_b_mem [IMG_WIDTH];
    logic [7:0]  line_a_rd_s;
    logic [7:0]  line_b_rd_s;
    logic [23:0] col_new_s;
    logic [23:0] col_mid_r;
    logic [23:0] col_old_r;
    logic        out_free_s;
    logic        beat_s;
    logic        last_pix_s;
    logic        emit_s;
    logic        frame_end_s;

    assign addr_s      = col_r[AW-1:0];
    assign line_a_rd_s = line_a_mem[addr_s];
    assign line_b_rd_s = line_b_mem[addr_s];
    // Top row of a column is the oldest line (lineB), bottom row is the live pixel.
    assign col_new_s   = {pix_in, line_a_rd_s, line_b_rd_s};
    assign out_free_s  = !window_valid || window_ready;
    assign beat_s      = pix_valid && pix_ready;
    assign last_pix_s  = (col_r == COL_LAST) && (row_r == ROW_LAST);
    assign emit_s      = beat_s && (row_r >= 12'd2) && (col_r >= 12'd2);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (beat_s && last_pix_s) state_next_s = FLUSH;
                else                      state_next_s = RUN;
            end
            FLUSH: begin
                if (out_free_s) state_next_s = IDLE;
                else            state_next_s = FLUSH;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        pix_ready   = 1'b0;
        frame_end_s = 1'b0;
        case (state_r)
            RUN:     pix_ready   = out_free_s;
            FLUSH:   frame_end_s = out_free_s;
            default: begin
                pix_ready   = 1'b0;
                frame_end_s = 1'b0;
            end
        endcase
    end

    // Raster position counters; a fresh start re-zeroes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_r <= 12'd0;
            row_r <= 12'd0;
        end else if ((state_r == IDLE) && start) begin
            col_r <= 12'd0;
            row_r <= 12'd0;
        end else if (beat_s) begin
            if (col_r == COL_LAST) begin
                col_r <= 12'd0;
                row_r <= (row_r == ROW_LAST) ? 12'd0 : row_r + 12'd1;
            end else begin
                col_r <= col_r + 12'd1;
            end
        end
    end

    // Line RAMs: lineA takes the live pixel, lineB inherits what lineA held (read-before-write).
    always_ff @(posedge clk) begin
        if (beat_s) begin
            line_a_mem[addr_s] <= pix_in;
            line_b_mem[addr_s] <= line_a_rd_s;
        end
    end

    // Column shift registers; the incoming column acts as the third (newest) column.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_mid_r <= 24'd0;
            col_old_r <= 24'd0;
        end else if (beat_s) begin
            col_old_r <= col_mid_r;
            col_mid_r <= col_new_s;
        end
    end

    // Output register: load on a qualifying beat, otherwise drain on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window       <= 72'd0;
            win_x        <= 12'd0;
            win_y        <= 12'd0;
            window_valid <= 1'b0;
        end else if (emit_s) begin
            window       <= {col_new_s, col_mid_r, col_old_r};
            win_x        <= col_r - 12'd1;
            win_y        <= row_r - 12'd1;
            window_valid <= 1'b1;
        end else if (window_ready) begin
            window_valid <= 1'b0;
        end
    end

    // End-of-frame pulse, raised as FLUSH hands back to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image: expected windows are cut
// straight out of an image array and checked by a monitor as the consumer accepts them.
module tb_sobel_window_gen;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [71:0] window;
    logic        window_valid;
    logic        window_ready = 1'b0;
    logic [11:0] win_x;
    logic [11:0] win_y;
    logic        frame_done;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .window(window), .window_valid(window_valid), .window_ready(window_ready),
        .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] win;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  img [H][W];
    int          checks = 0;
    int          passes = 0;
    int          ready_pct = 100;
    bit          hold_req = 1'b0;
    int          hold_cnt = 0;
    int          fd_count = 0;
    int          win_cnt = 0;
    bit          first_seen = 1'b0;
    logic [71:0] first_win = 72'd0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Fill the image and queue every interior window in raster order.
    task automatic build_frame(input bit inverted);
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = inverted ? 8'(255 - (5 * y + x)) : 8'(5 * y + x);
        for (int y = 1; y <= H - 2; y++)
            for (int x = 1; x <= W - 2; x++) begin
                e.win = 72'd0;
                for (int c = 0; c < 3; c++)
                    for (int r = 0; r < 3; r++)
                        e.win[8 * (3 * c + r) +: 8] = img[y - 1 + r][x - 1 + c];
                e.x = 12'(x);
                e.y = 12'(y);
                sb.push_back(e);
            end
    endtask

    // Consumer-side ready generator with an optional 5-cycle hold after the first window.
    always @(posedge clk) begin
        #1;
        if (hold_req && window_valid) begin
            hold_cnt = 5;
            hold_req = 1'b0;
        end
        if (hold_cnt > 0) begin
            window_ready = 1'b0;
            hold_cnt--;
        end else begin
            window_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on each accepted window and checks hold/stall behaviour.
    logic        prev_stall = 1'b0;
    logic        prev_fd = 1'b0;
    logic [71:0] prev_win = 72'd0;
    logic [23:0] prev_xy = 24'd0;
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (prev_stall) begin
                chk("hold_window", window, prev_win);
                chk("hold_xy", {48'd0, win_y, win_x}, {48'd0, prev_xy});
                chk("hold_valid", {71'd0, window_valid}, 72'd1);
            end
            if (window_valid && !window_ready)
                chk("ready_blocked", {71'd0, pix_ready}, 72'd0);
            if (window_valid && window_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_window: got %0h at (%0d,%0d) expected none", window, win_y, win_x);
                end else begin
                    e = sb.pop_front();
                    chk("window", window, e.win);
                    chk("win_xy", {48'd0, win_y, win_x}, {48'd0, e.y, e.x});
                    win_cnt++;
                    if (!first_seen) begin
                        first_win  = window;
                        first_seen = 1'b1;
                    end
                end
            end
            if (frame_done) begin
                fd_count++;
                chk("frame_done_width", {71'd0, prev_fd}, 72'd0);
                chk("frame_done_sb_empty", 72'(sb.size()), 72'd0);
            end
            prev_stall = window_valid && !window_ready;
            prev_win   = window;
            prev_xy    = {win_y, win_x};
            prev_fd    = frame_done;
        end else begin
            prev_stall = 1'b0;
            prev_fd    = 1'b0;
        end
    end

    // Feed one frame; optionally abort after abort_at beats or pulse start mid-frame.
    task automatic run_frame(input int pv_pct, input int abort_at, input int start_mid_at);
        int idx = 0;
        int guard = 0;
        int lx = 0;
        int ly = 0;
        int fd0;
        bit lat_pend = 1'b0;
        bit mid_done = 1'b0;
        bit beat;
        fd0        = fd_count;
        win_cnt    = 0;
        first_seen = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (idx < W * H && idx != abort_at && guard < 2000) begin
            pix_valid = ($urandom_range(99) < pv_pct);
            pix_in    = img[idx / W][idx % W];
            start     = (!mid_done && idx == start_mid_at);
            if (start) mid_done = 1'b1;
            @(negedge clk);
            if (lat_pend) begin
                chk("latency_valid", {71'd0, window_valid}, 72'd1);
                chk("latency_xy", {48'd0, win_y, win_x}, {48'd0, 12'(ly - 1), 12'(lx - 1)});
                lat_pend = 1'b0;
            end
            beat = pix_valid && pix_ready;
            if (beat) begin
                if (idx / W >= 2 && idx % W >= 2) begin
                    lat_pend = 1'b1;
                    lx = idx % W;
                    ly = idx / W;
                end
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        if (guard >= 2000) begin
            checks++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", idx, W * H);
        end
        @(negedge clk);
        if (lat_pend) begin
            chk("latency_valid", {71'd0, window_valid}, 72'd1);
            chk("latency_xy", {48'd0, win_y, win_x}, {48'd0, 12'(ly - 1), 12'(lx - 1)});
        end
        if (abort_at < 0) begin
            guard = 0;
            while (!frame_done && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            #1;
            chk("frame_done_count", 72'(fd_count), 72'(fd0 + 1));
            chk("window_count", 72'(win_cnt), 72'(NWIN));
            chk("sb_drained", 72'(sb.size()), 72'd0);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_pix_ready", {71'd0, pix_ready}, 72'd0);
        chk("rst_window_valid", {71'd0, window_valid}, 72'd0);
        chk("rst_frame_done", {71'd0, frame_done}, 72'd0);
        chk("rst_window", window, 72'd0);
        chk("rst_win_xy", {48'd0, win_y, win_x}, 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_pix_ready", {71'd0, pix_ready}, 72'd0);

        // Plain frame with the consumer always ready.
        build_frame(1'b0);
        run_frame(100, -1, -1);
        chk("first_window_t1", first_win, 72'h0C07020B06010A0500);

        // Consumer stalls for 5 cycles on the first window.
        build_frame(1'b0);
        hold_req = 1'b1;
        run_frame(100, -1, -1);
        chk("first_window_t2", first_win, 72'h0C07020B06010A0500);

        // Random gaps on both sides.
        ready_pct = 50;
        build_frame(1'b0);
        run_frame(50, -1, -1);
        ready_pct = 100;

        // Reset mid-frame after 12 beats, then a full frame.
        build_frame(1'b0);
        run_frame(100, 12, -1);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1 reset_n = 1'b1;
        build_frame(1'b0);
        run_frame(100, -1, -1);
        chk("first_window_t4", first_win, 72'h0C07020B06010A0500);

        // Back-to-back frames, second one with inverted pixels.
        build_frame(1'b0);
        run_frame(100, -1, -1);
        build_frame(1'b1);
        run_frame(100, -1, -1);
        chk("first_window_t5", first_win, 72'hF3F8FDF4F9FEF5FAFF);

        // start pulsed while running is ignored.
        build_frame(1'b0);
        run_frame(100, -1, 7);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
